// File: rtl/lbll_mon_pkg.sv
// rtl/lbll_mon_pkg.sv - shared state encoding and saturating increment for the lockstep monitor
package lbll_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYLD  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CMP    = 3'd3,
        ST_RPT    = 3'd4
    } mon_state_t;

    // Counters up to 32 bits wide are carried through this helper zero-extended.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/lbll_key_shifter.sv
// rtl/lbll_key_shifter.sv - serial key register with loaded-bit counter and key_valid flag
module lbll_key_shifter #(
    parameter int NKEY = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shift_en,
    input  logic            restart,
    input  logic            key_si,
    output logic [NKEY-1:0] key,
    output logic            key_valid
);

    localparam int BW = $clog2(NKEY + 1);
    localparam logic [BW-1:0] FULL = BW'(NKEY);

    logic [BW-1:0] bit_cnt;

    // A restart shift is the first bit of a fresh load, so the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key     <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            key <= {key[NKEY-2:0], key_si};
            if (restart) begin
                bit_cnt <= BW'(1);
            end else if (bit_cnt != FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign key_valid = (bit_cnt == FULL);

endmodule

// File: rtl/lockstep_equiv_monitor.sv
// rtl/lockstep_equiv_monitor.sv - gold vs key-locked lockstep comparator with trial statistics
module lockstep_equiv_monitor
    import lbll_mon_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int W      = 16,
    parameter int NKEY   = 64,
    parameter int SETTLE = 500,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_si,
    input  logic              key_shift,
    output logic [NKEY-1:0]   lbll_key,
    output logic              key_valid,
    input  logic              start,
    input  logic [NCH*W-1:0]  gold_data,
    input  logic              gold_vld,
    input  logic [NCH*W-1:0]  lock_data,
    input  logic              lock_vld,
    output logic              busy,
    output logic              done,
    output logic              trial_fail,
    output logic [NCH:0]      mismatch_mask,
    output logic [CNTW-1:0]   pass_cnt,
    output logic [CNTW-1:0]   fail_cnt,
    output logic              sticky_fail
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    mon_state_t state, state_nxt;
    logic [SW-1:0] settle_cnt;
    logic          vld_err;
    logic          launch;
    logic          in_settle;
    logic [NCH-1:0] chan_neq;
    logic [31:0]   pass_inc, fail_inc;

    // Key loading is only accepted outside a trial, so the key is frozen while busy.
    lbll_key_shifter #(.NKEY(NKEY)) u_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (key_shift && (state == ST_IDLE || state == ST_KEYLD)),
        .restart   (key_shift && (state == ST_IDLE)),
        .key_si    (key_si),
        .key       (lbll_key),
        .key_valid (key_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (key_shift) begin
                    state_nxt = ST_KEYLD;
                end else if (start && key_valid) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_KEYLD:  if (!key_shift) state_nxt = ST_IDLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_CMP;
            ST_CMP:    state_nxt = ST_RPT;
            ST_RPT:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_settle = 1'b0;
        case (state)
            ST_SETTLE: begin
                busy      = 1'b1;
                in_settle = 1'b1;
            end
            ST_CMP, ST_RPT: busy = 1'b1;
            default: begin
                busy      = 1'b0;
                in_settle = 1'b0;
            end
        endcase
    end

    assign launch = (state == ST_IDLE) && (state_nxt == ST_SETTLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vld_err    <= 1'b0;
        end else if (launch) begin
            settle_cnt <= SW'(1);
            vld_err    <= 1'b0;
        end else if (in_settle) begin
            if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (gold_vld != lock_vld) begin
                vld_err <= 1'b1;
            end
        end
    end

    always_comb begin
        chan_neq = '0;
        for (int i = 0; i < NCH; i++) begin
            chan_neq[i] = (gold_data[i*W +: W] != lock_data[i*W +: W]);
        end
    end

    assign pass_inc = sat_inc(32'(pass_cnt), 32'(CNT_MAX));
    assign fail_inc = sat_inc(32'(fail_cnt), 32'(CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_mask <= '0;
            done          <= 1'b0;
            trial_fail    <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            sticky_fail   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_CMP) begin
                mismatch_mask <= {vld_err, chan_neq};
            end
            if (state == ST_RPT) begin
                done       <= 1'b1;
                trial_fail <= |mismatch_mask;
                if (|mismatch_mask) begin
                    fail_cnt    <= fail_inc[CNTW-1:0];
                    sticky_fail <= 1'b1;
                end else begin
                    pass_cnt <= pass_inc[CNTW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_lockstep_equiv_monitor.sv
// tb/tb_lockstep_equiv_monitor.sv - directed bench with a timeline model of the lockstep monitor
`timescale 1ns/1ps
module tb_lockstep_equiv_monitor;

    localparam int NCH    = 4;
    localparam int W      = 16;
    localparam int NKEY   = 64;
    localparam int SETTLE = 500;
    localparam int CNTW   = 16;
    localparam logic [63:0] KEY_A  = 64'hA5A5_0F0F_1234_5678;
    localparam logic [63:0] DATA_A = 64'h1111_2222_3333_4444;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_si = 1'b0;
    logic              key_shift = 1'b0;
    logic [NKEY-1:0]   lbll_key;
    logic              key_valid;
    logic              start = 1'b0;
    logic [NCH*W-1:0]  gold_data = '0;
    logic              gold_vld = 1'b0;
    logic [NCH*W-1:0]  lock_data = '0;
    logic              lock_vld = 1'b0;
    logic              busy;
    logic              done;
    logic              trial_fail;
    logic [NCH:0]      mismatch_mask;
    logic [CNTW-1:0]   pass_cnt;
    logic [CNTW-1:0]   fail_cnt;
    logic              sticky_fail;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lockstep_equiv_monitor #(
        .NCH(NCH), .W(W), .NKEY(NKEY), .SETTLE(SETTLE), .CNTW(CNTW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_si        (key_si),
        .key_shift     (key_shift),
        .lbll_key      (lbll_key),
        .key_valid     (key_valid),
        .start         (start),
        .gold_data     (gold_data),
        .gold_vld      (gold_vld),
        .lock_data     (lock_data),
        .lock_vld      (lock_vld),
        .busy          (busy),
        .done          (done),
        .trial_fail    (trial_fail),
        .mismatch_mask (mismatch_mask),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .sticky_fail   (sticky_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a trial is tracked by its age in edges since the accepted start edge.
    logic [NKEY-1:0] m_key;
    int              m_bits;
    bit              m_loading;
    bit              m_active;
    int              m_age;
    bit              m_vld_err;
    logic [NCH:0]    m_mask;
    bit              m_fail;
    int              m_pass;
    int              m_failc;
    bit              m_sticky;
    bit              m_done;

    function automatic logic [NCH:0] model_mask(input logic [NCH*W-1:0] g, input logic [NCH*W-1:0] l,
                                                input bit verr);
        logic [NCH:0] m;
        m[NCH] = verr;
        for (int i = 0; i < NCH; i++) m[i] = (g[i*W +: W] != l[i*W +: W]);
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key <= '0; m_bits <= 0; m_loading <= 0; m_active <= 0; m_age <= 0;
            m_vld_err <= 0; m_mask <= '0; m_fail <= 0; m_pass <= 0; m_failc <= 0;
            m_sticky <= 0; m_done <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_age <= m_age + 1;
                if (m_age + 1 <= SETTLE && gold_vld != lock_vld) m_vld_err <= 1'b1;
                if (m_age + 1 == SETTLE + 1) m_mask <= model_mask(gold_data, lock_data, m_vld_err);
                if (m_age + 1 == SETTLE + 2) begin
                    m_done   <= 1'b1;
                    m_fail   <= (m_mask != 0);
                    m_sticky <= m_sticky || (m_mask != 0);
                    if (m_mask != 0) m_failc <= (m_failc == (1 << CNTW) - 1) ? m_failc : m_failc + 1;
                    else             m_pass  <= (m_pass == (1 << CNTW) - 1) ? m_pass : m_pass + 1;
                    m_active <= 1'b0;
                end
            end else if (key_shift) begin
                m_key     <= {m_key[NKEY-2:0], key_si};
                m_bits    <= m_loading ? ((m_bits < NKEY) ? m_bits + 1 : NKEY) : 1;
                m_loading <= 1'b1;
            end else if (m_loading) begin
                m_loading <= 1'b0;
            end else if (start && m_bits == NKEY) begin
                m_active  <= 1'b1;
                m_age     <= 0;
                m_vld_err <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lbll_key", lbll_key, m_key);
            chk("key_valid", 64'(key_valid), 64'(m_bits == NKEY));
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            chk("trial_fail", 64'(trial_fail), 64'(m_fail));
            chk("mismatch_mask", 64'(mismatch_mask), 64'(m_mask));
            chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
            chk("fail_cnt", 64'(fail_cnt), 64'(m_failc));
            chk("sticky_fail", 64'(sticky_fail), 64'(m_sticky));
        end
    end

    task automatic load_key(input logic [63:0] k, input bit with_start);
        for (int i = NKEY - 1; i >= 0; i--) begin
            key_si    = k[i];
            key_shift = 1'b1;
            start     = with_start && (i == NKEY - 1);
            @(posedge clk); #1;
            if (with_start && i == NKEY - 1) chk("shift_beats_start", 64'(busy), 64'd0);
            if (i == 1) chk("kv_before_last", 64'(key_valid), 64'd0);
        end
        key_shift = 1'b0;
        start     = 1'b0;
        key_si    = 1'b0;
        chk("kv_after_last", 64'(key_valid), 64'd1);
        chk("key_value", lbll_key, k);
        @(posedge clk); #1;
    endtask

    // vld_mode: 0 quiet, 1 equal pulse, 2 lock one cycle behind gold
    task automatic run_trial(input int vld_mode, input bit poke_busy, input bit rst_mid, output int lat);
        lat   = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (vld_mode == 1 && k == 10) begin gold_vld = 1; lock_vld = 1; end
            if (vld_mode == 1 && k == 11) begin gold_vld = 0; lock_vld = 0; end
            if (vld_mode == 2 && k == 10) gold_vld = 1;
            if (vld_mode == 2 && k == 11) begin gold_vld = 0; lock_vld = 1; end
            if (vld_mode == 2 && k == 12) lock_vld = 0;
            if (poke_busy && k == 100) begin key_shift = 1; key_si = 1; start = 1; end
            if (poke_busy && k == 103) begin key_shift = 0; key_si = 0; start = 0; end
            if (rst_mid && k == 250) begin
                rst_n = 1'b0;
                #1;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_key", lbll_key, 64'd0);
        rst_n = 1'b1;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("nokey_busy", 64'(busy), 64'd0);
        chk("nokey_pass", 64'(pass_cnt), 64'd0);

        load_key(KEY_A, 1'b0);

        gold_data = DATA_A; lock_data = DATA_A;
        run_trial(1, 1'b0, 1'b0, lat);
        chk("t1_latency", 64'(lat), 64'(SETTLE + 2));
        chk("t1_mask", 64'(mismatch_mask), 64'd0);
        chk("t1_pass", 64'(pass_cnt), 64'd1);

        lock_data[2*W +: W] = 16'h3334;
        run_trial(0, 1'b0, 1'b0, lat);
        chk("t2_mask", 64'(mismatch_mask), 64'b00100);
        chk("t2_fail", 64'(trial_fail), 64'd1);
        chk("t2_failcnt", 64'(fail_cnt), 64'd1);
        chk("t2_sticky", 64'(sticky_fail), 64'd1);

        lock_data = DATA_A;
        load_key(KEY_A, 1'b1);
        run_trial(2, 1'b0, 1'b0, lat);
        chk("t3_mask", 64'(mismatch_mask), 64'b10000);
        chk("t3_failcnt", 64'(fail_cnt), 64'd2);

        run_trial(0, 1'b1, 1'b0, lat);
        chk("t4_latency", 64'(lat), 64'(SETTLE + 2));
        chk("t4_key", lbll_key, KEY_A);
        chk("t4_pass", 64'(pass_cnt), 64'd2);
        chk("t4_fail", 64'(trial_fail), 64'd0);

        run_trial(0, 1'b0, 1'b1, lat);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_key", lbll_key, 64'd0);
        chk("rst_mid_kv", 64'(key_valid), 64'd0);
        chk("rst_mid_pass", 64'(pass_cnt), 64'd0);
        chk("rst_mid_fail", 64'(fail_cnt), 64'd0);
        chk("rst_mid_sticky", 64'(sticky_fail), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_key(KEY_A, 1'b0);
        run_trial(1, 1'b0, 1'b0, lat);
        chk("t5_latency", 64'(lat), 64'(SETTLE + 2));
        chk("t5_pass", 64'(pass_cnt), 64'd1);
        chk("t5_fail", 64'(fail_cnt), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
